// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl
// Windowed watchdog supervisor. Software arms it once with a timeout and an
// optional window, then must kick it with KICK_KEY after the window opens and
// before the timeout expires. A missed deadline raises wdt_irq (WARN). An
// unanswered warning or an illegal kick escalates to a reset request (BITE).
// The configuration stays locked until rst.

module watchdog_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WARN_CYCLES = 32,
   parameter int unsigned RST_PULSE   = 4,
   parameter logic [7:0]  KICK_KEY    = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_timeout,
   input  logic [CNT_W-1:0] cfg_window,
   input  logic             kick_valid,
   input  logic [7:0]       kick_key,
   output logic             kick_ack,
   output logic             kick_err,
   output logic             cfg_err,
   output logic             wdt_irq,
   output logic             wdt_rst_req,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned WCNT_W = (WARN_CYCLES > 1) ? $clog2(WARN_CYCLES) : 1;
   localparam int unsigned BCNT_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARN_CYCLES - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(RST_PULSE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      WARN  = 2'b10,
      BITE  = 2'b11
   } state_t;

   state_t            state;
   logic              lock;
   logic [CNT_W-1:0]  timeout_q;
   logic [CNT_W-1:0]  window_q;
   logic [CNT_W-1:0]  count;
   logic [WCNT_W-1:0] wcnt;
   logic [BCNT_W-1:0] bcnt;

   logic key_ok;
   logic cfg_legal;
   logic window_open;
   logic count_last;
   logic wcnt_last;
   logic bcnt_last;

   // Decode this cycle's events from the current state and inputs.
   always_comb begin
      key_ok      = (kick_key == KICK_KEY);
      cfg_legal   = (state == IDLE) && !lock && (cfg_timeout != '0) &&
                    (cfg_window < cfg_timeout);
      window_open = (count >= window_q);
      count_last  = (count == timeout_q - CNT_W'(1));
      wcnt_last   = (wcnt == WCNT_LAST);
      bcnt_last   = (bcnt == BCNT_LAST);
   end

   // Supervisor FSM: counters, lock and all registered outputs in one place.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lock        <= 1'b0;
         timeout_q   <= '0;
         window_q    <= '0;
         count       <= '0;
         wcnt        <= '0;
         bcnt        <= '0;
         kick_ack    <= 1'b0;
         kick_err    <= 1'b0;
         cfg_err     <= 1'b0;
         wdt_irq     <= 1'b0;
         wdt_rst_req <= 1'b0;
      end else begin
         // NOTE: the three pulse outputs default low every cycle and are only
         // raised below, so each is a clean one-cycle registered strobe.
         kick_ack <= 1'b0;
         kick_err <= 1'b0;
         cfg_err  <= cfg_we && !cfg_legal;

         case (state)
            IDLE: begin
               // Kicks are ignored until the watchdog is armed.
               if (cfg_we && cfg_legal) begin
                  timeout_q <= cfg_timeout;
                  window_q  <= cfg_window;
                  lock      <= 1'b1;
                  count     <= '0;
                  state     <= COUNT;
               end
            end

            COUNT: begin
               // A kick always takes priority over the deadline on the same cycle.
               if (kick_valid) begin
                  if (key_ok && window_open) begin
                     count    <= '0;
                     kick_ack <= 1'b1;
                  end else begin
                     count       <= '0;
                     bcnt        <= '0;
                     kick_err    <= 1'b1;
                     wdt_rst_req <= 1'b1;
                     state       <= BITE;
                  end
               end else if (count_last) begin
                  count   <= '0;
                  wcnt    <= '0;
                  wdt_irq <= 1'b1;
                  state   <= WARN;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end

            WARN: begin
               // Any correctly keyed kick rescues the warning; no window applies here.
               if (kick_valid) begin
                  wdt_irq <= 1'b0;
                  if (key_ok) begin
                     count    <= '0;
                     kick_ack <= 1'b1;
                     state    <= COUNT;
                  end else begin
                     bcnt        <= '0;
                     kick_err    <= 1'b1;
                     wdt_rst_req <= 1'b1;
                     state       <= BITE;
                  end
               end else if (wcnt_last) begin
                  wdt_irq     <= 1'b0;
                  bcnt        <= '0;
                  wdt_rst_req <= 1'b1;
                  state       <= BITE;
               end else begin
                  wcnt <= wcnt + WCNT_W'(1);
               end
            end

            BITE: begin
               // Hold the reset request for RST_PULSE cycles, then resume counting
               // with the configuration still locked.
               if (bcnt_last) begin
                  wdt_rst_req <= 1'b0;
                  count       <= '0;
                  state       <= COUNT;
               end else begin
                  bcnt <= bcnt + BCNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign state_o = state;
   assign count_o = count;

endmodule

// File: tb/tb_watchdog_ctrl.sv
// tb_watchdog_ctrl
// Directed stimulus against watchdog_ctrl. A deadline-based model tracks which
// phase the watchdog is in and when that phase began; the expected counter is
// simply the elapsed time in COUNT. A compare process checks every output on
// every falling edge, and directed steps pin latencies and pulses by hand.

module tb_watchdog_ctrl;

   localparam int         CNT_W       = 16;
   localparam int         WARN_CYCLES = 32;
   localparam int         RST_PULSE   = 4;
   localparam logic [7:0] KEY         = 8'hA5;
   localparam logic [7:0] BAD_KEY     = 8'h3C;

   localparam int P_IDLE  = 0;
   localparam int P_COUNT = 1;
   localparam int P_WARN  = 2;
   localparam int P_BITE  = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [CNT_W-1:0] cfg_timeout;
   logic [CNT_W-1:0] cfg_window;
   logic             kick_valid;
   logic [7:0]       kick_key;
   logic             kick_ack;
   logic             kick_err;
   logic             cfg_err;
   logic             wdt_irq;
   logic             wdt_rst_req;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] count_o;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   watchdog_ctrl #(
      .CNT_W       (CNT_W),
      .WARN_CYCLES (WARN_CYCLES),
      .RST_PULSE   (RST_PULSE),
      .KICK_KEY    (KEY)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_timeout (cfg_timeout),
      .cfg_window  (cfg_window),
      .kick_valid  (kick_valid),
      .kick_key    (kick_key),
      .kick_ack    (kick_ack),
      .kick_err    (kick_err),
      .cfg_err     (cfg_err),
      .wdt_irq     (wdt_irq),
      .wdt_rst_req (wdt_rst_req),
      .state_o     (state_o),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // cyc numbers the interval after each rising edge; a phase entered at the
   // edge that starts interval s has elapsed time cyc - s.
   int cyc     = 0;
   int m_phase = P_IDLE;
   int m_start = 0;
   int m_to    = 0;
   int m_win   = 0;
   bit m_lock  = 1'b0;
   bit m_ack   = 1'b0;
   bit m_kerr  = 1'b0;
   bit m_cerr  = 1'b0;

   int m_el;
   bit m_good;
   bit m_cfg_ok;

   always_comb begin
      m_el     = cyc - m_start;
      m_good   = kick_valid && (kick_key == KEY) &&
                 (m_phase == P_WARN || (m_phase == P_COUNT && m_el >= m_win));
      m_cfg_ok = (m_phase == P_IDLE) && !m_lock && (cfg_timeout != 0) &&
                 (cfg_window < cfg_timeout);
   end

   always @(posedge clk) begin
      m_ack  <= 1'b0;
      m_kerr <= 1'b0;
      cyc    <= cyc + 1;
      if (rst) begin
         m_phase <= P_IDLE;
         m_lock  <= 1'b0;
         m_start <= cyc + 1;
         m_cerr  <= 1'b0;
      end else begin
         m_cerr <= cfg_we && !m_cfg_ok;
         if (m_phase == P_IDLE) begin
            if (cfg_we && m_cfg_ok) begin
               m_phase <= P_COUNT;
               m_start <= cyc + 1;
               m_lock  <= 1'b1;
               m_to    <= int'(cfg_timeout);
               m_win   <= int'(cfg_window);
            end
         end else if (kick_valid && m_phase != P_BITE) begin
            m_start <= cyc + 1;
            if (m_good) begin
               m_phase <= P_COUNT;
               m_ack   <= 1'b1;
            end else begin
               m_phase <= P_BITE;
               m_kerr  <= 1'b1;
            end
         end else if (m_phase == P_COUNT && cyc + 1 == m_start + m_to) begin
            m_phase <= P_WARN;
            m_start <= cyc + 1;
         end else if (m_phase == P_WARN && cyc + 1 == m_start + WARN_CYCLES) begin
            m_phase <= P_BITE;
            m_start <= cyc + 1;
         end else if (m_phase == P_BITE && cyc + 1 == m_start + RST_PULSE) begin
            m_phase <= P_COUNT;
            m_start <= cyc + 1;
         end
      end
   end

   // ---------------------------------------------------------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model on every falling edge.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("m_state",    32'(state_o),     32'(m_phase));
         check("m_count",    32'(count_o),     (m_phase == P_COUNT) ? 32'(m_el) : 32'd0);
         check("m_irq",      32'(wdt_irq),     32'(m_phase == P_WARN));
         check("m_rst_req",  32'(wdt_rst_req), 32'(m_phase == P_BITE));
         check("m_kick_ack", 32'(kick_ack),    32'(m_ack));
         check("m_kick_err", 32'(kick_err),    32'(m_kerr));
         check("m_cfg_err",  32'(cfg_err),     32'(m_cerr));
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic idle();
      cfg_we     = 1'b0;
      kick_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_cfg(input int to, input int win);
      cfg_we      = 1'b1;
      cfg_timeout = CNT_W'(to);
      cfg_window  = CNT_W'(win);
      @(negedge clk);
      cfg_we      = 1'b0;
   endtask

   task automatic kick(input logic [7:0] key);
      kick_valid = 1'b1;
      kick_key   = key;
      @(negedge clk);
      kick_valid = 1'b0;
   endtask

   task automatic wait_count(input int v, input int budget);
      int k = 0;
      while (count_o !== CNT_W'(v) && k < budget) begin
         idle();
         k++;
      end
      check("wait_count", 32'(count_o), 32'(v));
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget);
      int k = 0;
      while (state_o !== s && k < budget) begin
         idle();
         k++;
      end
      check("wait_state", 32'(state_o), 32'(s));
   endtask

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      rst         = 1'b1;
      cfg_we      = 1'b0;
      cfg_timeout = '0;
      cfg_window  = '0;
      kick_valid  = 1'b0;
      kick_key    = '0;
      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_state",   32'(state_o),     32'd0);
      check("rst_count",   32'(count_o),     32'd0);
      check("rst_irq",     32'(wdt_irq),     32'd0);
      check("rst_rst_req", 32'(wdt_rst_req), 32'd0);

      // 1: arm 100/20 and let it run out completely.
      do_cfg(100, 20);
      check("t1_state", 32'(state_o), 32'd1);
      k = 0;
      while (wdt_irq !== 1'b1 && k < 300) begin idle(); k++; end
      check("t1_irq_latency", 32'(k), 32'd100);
      k = 0;
      while (wdt_rst_req !== 1'b1 && k < 100) begin idle(); k++; end
      check("t1_bite_latency", 32'(k), 32'd32);
      k = 0;
      while (wdt_rst_req === 1'b1 && k < 20) begin idle(); k++; end
      check("t1_bite_hold", 32'(k), 32'd4);
      check("t1_post_state", 32'(state_o), 32'd1);
      check("t1_post_count", 32'(count_o), 32'd0);

      // 2: good kick at 50, then periodic kicks every 60 cycles.
      wait_count(50, 100);
      kick(KEY);
      check("t2_ack",   32'(kick_ack), 32'd1);
      check("t2_count", 32'(count_o),  32'd0);
      for (int i = 0; i < 4; i++) begin
         repeat (59) idle();
         kick(KEY);
         check("t2_periodic_ack", 32'(kick_ack), 32'd1);
         check("t2_periodic_irq", 32'(wdt_irq),  32'd0);
      end

      // 3: early kick, then a wrong key inside the window.
      wait_count(10, 100);
      kick(KEY);
      check("t3_early_err",   32'(kick_err), 32'd1);
      check("t3_early_state", 32'(state_o),  32'd3);
      wait_state(2'b01, 10);
      wait_count(50, 100);
      kick(BAD_KEY);
      check("t3_key_err",   32'(kick_err), 32'd1);
      check("t3_key_state", 32'(state_o),  32'd3);
      wait_state(2'b01, 10);

      // 4: rescue WARN at wcnt=5, then at the last WARN cycle, then a bad key in WARN.
      wait_state(2'b10, 200);
      repeat (5) idle();
      kick(KEY);
      check("t4_irq",     32'(wdt_irq),     32'd0);
      check("t4_state",   32'(state_o),     32'd1);
      check("t4_count",   32'(count_o),     32'd0);
      check("t4_ack",     32'(kick_ack),    32'd1);
      check("t4_rst_req", 32'(wdt_rst_req), 32'd0);
      wait_state(2'b10, 200);
      repeat (WARN_CYCLES - 1) idle();
      kick(KEY);
      check("t4_last_ack",     32'(kick_ack),    32'd1);
      check("t4_last_state",   32'(state_o),     32'd1);
      check("t4_last_rst_req", 32'(wdt_rst_req), 32'd0);
      wait_state(2'b10, 200);
      kick(BAD_KEY);
      check("t4_bad_err",     32'(kick_err),    32'd1);
      check("t4_bad_irq",     32'(wdt_irq),     32'd0);
      check("t4_bad_rst_req", 32'(wdt_rst_req), 32'd1);
      wait_state(2'b01, 10);

      // 5: writes while armed are rejected and leave the timeout at 100.
      do_cfg(50, 10);
      check("t5_locked_err",   32'(cfg_err), 32'd1);
      check("t5_locked_state", 32'(state_o), 32'd1);
      check("t5_locked_count", 32'(count_o), 32'd1);
      k = 0;
      while (wdt_irq !== 1'b1 && k < 300) begin idle(); k++; end
      check("t5_irq_latency", 32'(k), 32'd99);
      cfg_we      = 1'b1;
      cfg_timeout = CNT_W'(200);
      cfg_window  = CNT_W'(0);
      kick(KEY);
      cfg_we = 1'b0;
      check("t5_concurrent_cfg_err", 32'(cfg_err),  32'd1);
      check("t5_concurrent_ack",     32'(kick_ack), 32'd1);
      check("t5_concurrent_state",   32'(state_o),  32'd1);
      do_reset();
      check("t5_rst_state", 32'(state_o), 32'd0);
      do_cfg(0, 0);
      check("t5_zero_err",   32'(cfg_err), 32'd1);
      check("t5_zero_state", 32'(state_o), 32'd0);
      do_cfg(100, 100);
      check("t5_win_err",   32'(cfg_err), 32'd1);
      check("t5_win_state", 32'(state_o), 32'd0);
      do_cfg(100, 99);
      check("t5_ok_err",   32'(cfg_err), 32'd0);
      check("t5_ok_state", 32'(state_o), 32'd1);

      // 6: kick on the deadline cycle, kick one below the window, reset in BITE.
      wait_count(99, 200);
      kick(KEY);
      check("t6_deadline_ack",   32'(kick_ack), 32'd1);
      check("t6_deadline_irq",   32'(wdt_irq),  32'd0);
      check("t6_deadline_count", 32'(count_o),  32'd0);
      wait_count(98, 200);
      kick(KEY);
      check("t6_window_err",   32'(kick_err), 32'd1);
      check("t6_window_state", 32'(state_o),  32'd3);
      idle();
      do_reset();
      check("t6_rst_state",   32'(state_o),     32'd0);
      check("t6_rst_rst_req", 32'(wdt_rst_req), 32'd0);
      do_cfg(1, 0);
      check("t6_rearm_state", 32'(state_o), 32'd1);
      check("t6_rearm_err",   32'(cfg_err), 32'd0);
      idle();
      check("t6_min_irq",   32'(wdt_irq), 32'd1);
      check("t6_min_state", 32'(state_o), 32'd2);
      kick(KEY);
      check("t6_min_ack", 32'(kick_ack), 32'd1);
      idle();
      idle();

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
